irq_ctrl: RTL and testbench
===========================

// Module: irq_ctrl
// PURPOSE
//  Port-mapped interrupt controller that shares the single PacoBlaze interrupt input between NSRC peripheral sources.
//  - Synchronises and edge-detects each source, then latches it as pending.
//  - Applies a mask and drives interrupt until interrupt_ack; exposes PEND/MASK/CAUSE/EOI on the port_id bus.
//  Sits beside outport/inport in the top level; value_out is ORed into in_port.
// PARAMETERS
//  NSRC   8      number of interrupt sources, 1..8
//  BASE   8'h10  port_id of the first register; BASE..BASE+3 are decoded, BASE must be 4-aligned
// PORTS
//  clk        in   1     system clock, all state on rising edge
//  rst        in   1     asynchronous reset, ACTIVE-LOW; all state cleared while rst==0
//  src_in     in   NSRC  asynchronous interrupt sources, rising-edge triggered
//  address    in   8     CPU port_id
//  value_in   in   8     CPU out_port
//  wen        in   1     CPU write_strobe, one-cycle pulse
//  ren        in   1     CPU read_strobe (no read side effects; unused except for assertions)
//  value_out  out  8     registered read data; 0 when address is not BASE..BASE+3
//  irq        out  1     to CPU interrupt, registered
//  iak        in   1     CPU interrupt_ack, one-cycle pulse
// BEHAVIOUR
//  Reset values
//  - value_out=0, irq=0, PEND=0, MASK=0, CAUSE=0, FSM=IDLE, all sync flops 0.
//  Source path
//  - 2-flop synchroniser, then edge = s2 & ~s3.
//  - PEND[i] sets on the clock after edge[i].
//  - Latency: src_in rise sampled at edge k -> PEND set at edge k+3 -> irq set at edge k+4.
//  Registers (offset from BASE; bits >= NSRC read 0, writes ignored)
//  - +0 PEND  R  / W1C: a 1 in value_in clears that bit.
//  - +1 MASK  R/W: 1 = enabled.
//  - +2 CAUSE R  only: [7] = valid, [2:0] = index of serviced source; writes ignored.
//  - +3 EOI   W  only: any value; reads 0.
//  - value_out <= decoded read mux of the current address, every clock (valid 1 clk after port_id is stable).
//  FSM
//  - IDLE: when |(PEND&MASK), go to REQ and set irq=1.
//  - REQ: irq held at 1.
//    - On iak: CAUSE <= {1'b1, index of lowest-numbered set bit of PEND&MASK, sampled at iak}; clear that PEND bit; irq=0; go to SERV.
//    - If PEND&MASK becomes 0 before iak (W1C or mask write): irq=0, back to IDLE, CAUSE unchanged.
//  - SERV: irq=0, new edges keep latching into PEND.
//    - Write to EOI: CAUSE[7]<=0, go to IDLE; irq may re-assert on the next clock.
//  Boundary rules
//  - Edge and W1C of the same PEND bit in the same cycle: the set wins.
//  - Edge on a bit while that bit is being cleared by iak: the bit stays set (new event, not lost).
//  - iak outside REQ: ignored. EOI outside SERV: ignored.
//  - Masked pending bits are retained; unmasking later raises irq.
//  - Repeated edges while PEND=1 collapse into one event (no counting).
//  - Priority: fixed, lowest index highest.
//  - rst low at any point: immediate return to the reset values, including mid-REQ (irq drops asynchronously).
// STRUCTURE
//  - Shared include irq_ctrl_inc.v holds:
//    - register offsets IRQ_PEND=0, IRQ_MASK=1, IRQ_CAUSE=2, IRQ_EOI=3;
//    - FSM state encodings IDLE/REQ/SERV;
//    - CAUSE valid bit position.
//  - One sub-module irq_sync_edge: 1-bit 2-flop synchroniser + edge detect, instantiated NSRC times by generate.
//  - Priority encoder, register file and FSM live in irq_ctrl.
// TESTING
//  1. Reset low with src_in=8'hFF, then release with MASK=0 -> irq=0, PEND=0 until a new rising edge; after src 0->1 on bit 3, PEND=8'h08, irq stays 0.
//  2. MASK<=8'h0A, pulse src[1] and src[3] together -> irq=1 four clocks after the edge; iak -> CAUSE=8'h81, PEND=8'h08, irq=0.
//     Then EOI -> irq=1 again; iak -> CAUSE=8'h83.
//  3. In REQ with PEND=8'h02 and MASK=8'h02, write PEND W1C 8'h02 before iak -> irq=0, FSM IDLE, CAUSE unchanged.
//  4. Edge on src[2] in the same cycle as W1C 8'h04 -> PEND[2]=1. Edge arriving on the iak clear cycle -> bit remains 1.
//  5. Read port_id BASE+1 after writing 8'h5A with NSRC=4 -> value_out=8'h0A. Read port_id BASE+4 -> value_out=8'h00.
//  6. Assert rst low while in REQ -> irq=0 immediately; PEND, MASK and CAUSE read 0 after release.

Source files
------------

// File: rtl/irq_ctrl_pkg.sv
// Shared constants for the port-mapped interrupt controller:
// register offsets, FSM encodings, CAUSE layout and helpers.
package irq_ctrl_pkg;

    localparam logic [1:0] IRQ_PEND  = 2'd0;
    localparam logic [1:0] IRQ_MASK  = 2'd1;
    localparam logic [1:0] IRQ_CAUSE = 2'd2;
    localparam logic [1:0] IRQ_EOI   = 2'd3;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_SERV = 2'd2;

    localparam int CAUSE_VLD = 7;

    // Lowest set bit wins.
    function automatic logic [2:0] prio_idx(input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) idx = i[2:0];
        end
        return idx;
    endfunction

    function automatic logic [7:0] mk_cause(input logic [2:0] idx);
        logic [7:0] c;
        c = 8'(idx);
        c[CAUSE_VLD] = 1'b1;
        return c;
    endfunction

endpackage

// File: rtl/irq_ctrl_if.sv
// CPU-side bundle of the interrupt controller: port bus
// (address/value_in/wen/ren/value_out) plus irq/iak pair.
interface irq_ctrl_if;
    logic [7:0] address;
    logic [7:0] value_in;
    logic       wen;
    logic       ren;
    logic [7:0] value_out;
    logic       irq;
    logic       iak;

    modport master (
        output address, value_in, wen, ren, iak,
        input  value_out, irq
    );

    modport slave (
        input  address, value_in, wen, ren, iak,
        output value_out, irq
    );
endinterface

// File: rtl/irq_sync_edge.sv
// One source: 2-flop synchroniser, rising-edge detect, registered pulse.
// Ports: clk, rst (async, low), arm (edge enable), src (async in), rise (out).
module irq_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic arm,
    input  logic src,
    output logic rise
);
    logic s1, s2, s3;

    // arm stays low until s3 holds a real sample, so a level already
    // high at reset release is not mistaken for a new edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            s3   <= 1'b0;
            rise <= 1'b0;
        end else begin
            s1   <= src;
            s2   <= s1;
            s3   <= s2;
            rise <= arm & s2 & ~s3;
        end
    end
endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller sharing one CPU interrupt among NSRC sources.
// Ports: clk, rst (async, low), src_in[NSRC], bus (irq_ctrl_if.slave).
module irq_ctrl
    import irq_ctrl_pkg::*;
#(
    parameter int         NSRC = 8,
    parameter logic [7:0] BASE = 8'h10
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NSRC-1:0] src_in,
    irq_ctrl_if.slave       bus
);
    logic [2:0]      warm;
    logic [NSRC-1:0] rise;
    logic [NSRC-1:0] pend, pend_n;
    logic [NSRC-1:0] mask, mask_n;
    logic [NSRC-1:0] act;
    logic [7:0]      cause;
    logic [1:0]      state;
    logic [7:0]      act8, clr8, rdata;
    logic [2:0]      idx;
    logic [1:0]      ofs;
    logic            hit, wr_pend, wr_mask, wr_eoi, take;

    // Fills alongside the synchroniser chain after reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) warm <= 3'b000;
        else      warm <= {warm[1:0], 1'b1};
    end

    for (genvar g = 0; g < NSRC; g++) begin : g_src
        irq_sync_edge u_sync (
            .clk  (clk),
            .rst  (rst),
            .arm  (warm[2]),
            .src  (src_in[g]),
            .rise (rise[g])
        );
    end

    assign hit     = bus.address[7:2] == BASE[7:2];
    assign ofs     = bus.address[1:0];
    assign wr_pend = bus.wen && hit && ofs == IRQ_PEND;
    assign wr_mask = bus.wen && hit && ofs == IRQ_MASK;
    assign wr_eoi  = bus.wen && hit && ofs == IRQ_EOI;

    assign act  = pend & mask;
    assign act8 = 8'(act);
    assign idx  = prio_idx(act8);
    assign clr8 = 8'd1 << idx;
    assign take = state == ST_REQ && bus.iak && |act;

    // New edges are applied last so they beat both clear paths.
    always_comb begin
        pend_n = pend;
        if (wr_pend) pend_n = pend_n & ~bus.value_in[NSRC-1:0];
        if (take)    pend_n = pend_n & ~clr8[NSRC-1:0];
        pend_n = pend_n | rise;
        mask_n = wr_mask ? bus.value_in[NSRC-1:0] : mask;
    end

    always_comb begin
        rdata = 8'h00;
        unique case (1'b1)
            hit && ofs == IRQ_PEND:  rdata = 8'(pend);
            hit && ofs == IRQ_MASK:  rdata = 8'(mask);
            hit && ofs == IRQ_CAUSE: rdata = cause;
            default:                 rdata = 8'h00;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend          <= '0;
            mask          <= '0;
            cause         <= 8'h00;
            state         <= ST_IDLE;
            bus.irq       <= 1'b0;
            bus.value_out <= 8'h00;
        end else begin
            pend          <= pend_n;
            mask          <= mask_n;
            bus.value_out <= rdata;
            case (state)
                ST_IDLE: begin
                    if (|act) begin
                        state   <= ST_REQ;
                        bus.irq <= 1'b1;
                    end
                end
                ST_REQ: begin
                    if (take) begin
                        cause   <= mk_cause(idx);
                        bus.irq <= 1'b0;
                        state   <= ST_SERV;
                    end else if (~|(pend_n & mask_n)) begin
                        bus.irq <= 1'b0;
                        state   <= ST_IDLE;
                    end
                end
                ST_SERV: begin
                    if (wr_eoi) begin
                        cause[CAUSE_VLD] <= 1'b0;
                        state            <= ST_IDLE;
                    end
                end
                default: begin
                    bus.irq <= 1'b0;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

    a_no_rw: assert property (
        @(posedge clk) disable iff (!rst) !(bus.wen && bus.ren)
    );
endmodule

// File: tb/tb_irq_ctrl.sv
// Bench for irq_ctrl: register table, scoreboarded reads,
// hand-written sequences for latency, priority and boundary cases.
module tb_irq_ctrl;
    logic       clk;
    logic       rst;
    logic [7:0] src;

    irq_ctrl_if bus ();
    irq_ctrl_if bus4 ();

    irq_ctrl #(.NSRC(8), .BASE(8'h10)) dut (
        .clk    (clk),
        .rst    (rst),
        .src_in (src),
        .bus    (bus.slave)
    );

    irq_ctrl #(.NSRC(4), .BASE(8'h10)) dut4 (
        .clk    (clk),
        .rst    (rst),
        .src_in (src[3:0]),
        .bus    (bus4.slave)
    );

    assign bus4.address  = bus.address;
    assign bus4.value_in = bus.value_in;
    assign bus4.wen      = bus.wen;
    assign bus4.ren      = bus.ren;
    assign bus4.iak      = bus.iak;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      nm;
        logic [7:0] exp;
        bit         sel4;
    } sb_t;

    typedef struct {
        bit         do_wr;
        logic [7:0] wa;
        logic [7:0] wd;
        logic [7:0] ra;
        logic [7:0] exp;
        string      nm;
    } vec_t;

    sb_t  sbq[$];
    vec_t tbl[10];
    int   errs;
    int   checks;

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [7:0] act,
                       input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %02h expected %02h", nm, act, exp);
        end
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        bus.address  = a;
        bus.value_in = d;
        bus.wen      = 1'b1;
        cyc(1);
        bus.wen      = 1'b0;
        bus.address  = 8'h00;
        bus.value_in = 8'h00;
    endtask

    task automatic rd(input logic [7:0] a, input logic [7:0] exp,
                      input string nm, input bit sel4 = 1'b0);
        sb_t e;
        sb_t g;
        e.nm   = nm;
        e.exp  = exp;
        e.sel4 = sel4;
        bus.address = a;
        bus.ren     = 1'b1;
        sbq.push_back(e);
        cyc(1);
        bus.ren     = 1'b0;
        bus.address = 8'h00;
        if (sbq.size() == 0) begin
            checks++;
            errs++;
            $display("FAIL %s: scoreboard empty", nm);
        end else begin
            g = sbq.pop_front();
            chk(g.nm, g.sel4 ? bus4.value_out : bus.value_out, g.exp);
        end
    endtask

    task automatic pulse_iak();
        bus.iak = 1'b1;
        cyc(1);
        bus.iak = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        errs         = 0;
        checks       = 0;
        src          = 8'hFF;
        rst          = 1'b0;
        bus.address  = 8'h00;
        bus.value_in = 8'h00;
        bus.wen      = 1'b0;
        bus.ren      = 1'b0;
        bus.iak      = 1'b0;

        tbl[0] = '{1'b1, 8'h10, 8'h00, 8'h10, 8'h08, "pend_w1c_zero"};
        tbl[1] = '{1'b1, 8'h10, 8'hF7, 8'h10, 8'h08, "pend_w1c_other"};
        tbl[2] = '{1'b1, 8'h10, 8'h08, 8'h10, 8'h00, "pend_w1c_hit"};
        tbl[3] = '{1'b1, 8'h11, 8'h5A, 8'h11, 8'h5A, "mask_rw_5a"};
        tbl[4] = '{1'b1, 8'h11, 8'hA5, 8'h11, 8'hA5, "mask_rw_a5"};
        tbl[5] = '{1'b1, 8'h11, 8'h00, 8'h11, 8'h00, "mask_rw_00"};
        tbl[6] = '{1'b1, 8'h12, 8'hFF, 8'h12, 8'h00, "cause_ro"};
        tbl[7] = '{1'b1, 8'h13, 8'h3C, 8'h13, 8'h00, "eoi_wo"};
        tbl[8] = '{1'b0, 8'h00, 8'h00, 8'h14, 8'h00, "beyond_base"};
        tbl[9] = '{1'b0, 8'h00, 8'h00, 8'h0F, 8'h00, "below_base"};

        // Reset with all sources high, no spurious events after release.
        cyc(3);
        chk("rst_irq", {7'd0, bus.irq}, 8'h00);
        chk("rst_vout", bus.value_out, 8'h00);
        rst = 1'b1;
        cyc(6);
        rd(8'h10, 8'h00, "pend_after_rel");
        chk("irq_after_rel", {7'd0, bus.irq}, 8'h00);
        src[3] = 1'b0;
        cyc(4);
        src[3] = 1'b1;
        cyc(6);
        rd(8'h10, 8'h08, "pend_bit3");
        chk("irq_masked", {7'd0, bus.irq}, 8'h00);

        for (int i = 0; i < 10; i++) begin
            if (tbl[i].do_wr) wr(tbl[i].wa, tbl[i].wd);
            rd(tbl[i].ra, tbl[i].exp, tbl[i].nm);
        end

        // Narrow instance: bits above NSRC read as zero.
        wr(8'h11, 8'h5A);
        rd(8'h11, 8'h0A, "n4_mask", 1'b1);
        rd(8'h11, 8'h5A, "n8_mask");
        rd(8'h14, 8'h00, "n4_beyond", 1'b1);

        // Two sources at once: latency and priority.
        wr(8'h11, 8'h0A);
        src[1] = 1'b0;
        src[3] = 1'b0;
        cyc(4);
        src[1] = 1'b1;
        src[3] = 1'b1;
        cyc(4);
        chk("irq_lat3", {7'd0, bus.irq}, 8'h00);
        cyc(1);
        chk("irq_lat4", {7'd0, bus.irq}, 8'h01);
        pulse_iak();
        chk("irq_after_iak", {7'd0, bus.irq}, 8'h00);
        rd(8'h12, 8'h81, "cause_81");
        rd(8'h10, 8'h08, "pend_left_08");
        chk("irq_serv_hold", {7'd0, bus.irq}, 8'h00);
        wr(8'h13, 8'h00);
        cyc(1);
        chk("irq_after_eoi", {7'd0, bus.irq}, 8'h01);
        pulse_iak();
        rd(8'h12, 8'h83, "cause_83");
        rd(8'h10, 8'h00, "pend_empty");
        wr(8'h13, 8'h00);
        rd(8'h12, 8'h03, "cause_eoi_vld0");
        pulse_iak();
        rd(8'h12, 8'h03, "iak_idle_ign");
        chk("irq_idle", {7'd0, bus.irq}, 8'h00);

        // Withdrawal by W1C while requesting.
        wr(8'h11, 8'h02);
        src[1] = 1'b0;
        cyc(4);
        src[1] = 1'b1;
        cyc(6);
        chk("irq_req2", {7'd0, bus.irq}, 8'h01);
        wr(8'h10, 8'h02);
        chk("irq_withdrawn", {7'd0, bus.irq}, 8'h00);
        rd(8'h12, 8'h03, "cause_unchg");
        rd(8'h10, 8'h00, "pend_withdrawn");
        pulse_iak();
        rd(8'h12, 8'h03, "iak_after_wd");

        // Edge vs W1C on the same cycle.
        src[2] = 1'b0;
        cyc(4);
        src[2] = 1'b1;
        cyc(6);
        rd(8'h10, 8'h04, "pend2_set");
        src[2] = 1'b0;
        cyc(4);
        src[2] = 1'b1;
        cyc(3);
        wr(8'h10, 8'h04);
        rd(8'h10, 8'h04, "edge_beats_w1c");
        wr(8'h10, 8'h04);
        rd(8'h10, 8'h00, "w1c_plain");

        // Edge vs iak clear on the same cycle.
        wr(8'h11, 8'h04);
        src[2] = 1'b0;
        cyc(4);
        src[2] = 1'b1;
        cyc(6);
        chk("irq_req3", {7'd0, bus.irq}, 8'h01);
        src[2] = 1'b0;
        cyc(4);
        src[2] = 1'b1;
        cyc(3);
        pulse_iak();
        chk("irq_serv3", {7'd0, bus.irq}, 8'h00);
        rd(8'h12, 8'h82, "cause_82");
        rd(8'h10, 8'h04, "edge_beats_iak");
        wr(8'h13, 8'h00);
        cyc(1);
        chk("irq_reassert", {7'd0, bus.irq}, 8'h01);
        pulse_iak();
        rd(8'h12, 8'h82, "cause_82b");
        rd(8'h10, 8'h00, "pend_clr3");
        wr(8'h13, 8'h00);

        // Asynchronous reset while requesting.
        src[2] = 1'b0;
        cyc(4);
        src[2] = 1'b1;
        cyc(6);
        chk("irq_req4", {7'd0, bus.irq}, 8'h01);
        rst = 1'b0;
        #1;
        chk("irq_async_rst", {7'd0, bus.irq}, 8'h00);
        cyc(2);
        rst = 1'b1;
        cyc(4);
        rd(8'h10, 8'h00, "rst_pend");
        rd(8'h11, 8'h00, "rst_mask");
        rd(8'h12, 8'h00, "rst_cause");
        chk("rst_irq_end", {7'd0, bus.irq}, 8'h00);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
